// File: rtl/memio_pkg.sv
// Shared definitions for the CPU memory-bus responders: FSM states and RAM window constants.
package memio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [2:0] RAM_WINDOW_TAG = 3'b001;
  localparam int         RAM_ADDR_WIDTH = 13;
  localparam logic [7:0] OOB_READ_VALUE = 8'hFF;

endpackage

// File: rtl/ram_array.sv
// Synchronous single-port word array with registered read; contents survive reset.
module ram_array
  import memio_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Read-first: a same-cycle write returns the old word on rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_responder.sv
// RAM-window responder: wait-state FSM, byte array and tri-state read-back onto the shared bus.
// Optional window check on address[15:13] is enabled by defining RAM_BOUNDS_CHECK_EN.
module ram_responder
  import memio_pkg::*;
#(
  parameter int ADDR_WIDTH  = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [15:0]           address,
  input  logic                  ram_enable,
  input  logic                  write_bar,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  bus_error
);

  localparam logic [3:0] WAIT_CNT_INIT = 4'(WAIT_STATES);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  op_write_reg, op_write_next;
  logic [3:0]            wait_cnt_reg, wait_cnt_next;
  logic                  ready_reg;
  logic                  oob_reg, oob_next;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  drive;

  generate
    if (ADDR_WIDTH < 16) begin : g_upper_addr
      logic unused_addr_bits;
      assign unused_addr_bits = ^address[15:ADDR_WIDTH];
    end
  endgenerate

`ifdef RAM_BOUNDS_CHECK_EN
  logic bus_error_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      oob_reg       <= 1'b0;
      bus_error_reg <= 1'b0;
    end else begin
      oob_reg       <= oob_next;
      bus_error_reg <= (state_reg == ACCESS) && oob_reg;
    end
  end

  assign bus_error = bus_error_reg;
  assign rd_val    = oob_reg ? '1 : mem_rdata;
`else
  assign oob_reg   = 1'b0;
  assign bus_error = 1'b0;
  assign rd_val    = mem_rdata;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      op_write_reg <= 1'b0;
      wait_cnt_reg <= '0;
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      op_write_reg <= op_write_next;
      wait_cnt_reg <= wait_cnt_next;
      ready_reg    <= (state_reg == ACCESS);
    end
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    op_write_next = op_write_reg;
    wait_cnt_next = wait_cnt_reg;
    oob_next      = oob_reg;
    case (state_reg)
      IDLE: begin
        if (!ram_enable) begin
          addr_next     = address[ADDR_WIDTH-1:0];
          op_write_next = !write_bar;
          wait_cnt_next = WAIT_CNT_INIT;
          oob_next      = (address[15:13] != RAM_WINDOW_TAG);
          state_next    = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        wait_cnt_next = wait_cnt_reg - 4'd1;
        // Deselect wins over the final wait cycle so an aborted write never commits.
        if (ram_enable) begin
          state_next = IDLE;
        end else if (wait_cnt_reg == 4'd1) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (ram_enable) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign mem_we = (state_reg == ACCESS) && op_write_reg && !oob_reg;

  ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (addr_reg),
    .wdata(data),
    .rdata(mem_rdata)
  );

  // Select and strobe terms are live so the bus frees in the same cycle the initiator backs off.
  assign drive = (state_reg == HOLD) && !op_write_reg && !ram_enable && write_bar;
  assign data  = drive ? rd_val : 'z;
  assign ready = ready_reg;

endmodule

// File: tb/tb_ram_responder.sv
// Randomized self-checking bench for ram_responder against an array-based memory model.
module tb_ram_responder;

  localparam int WS = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] address = 16'h0;
  logic        ram_enable = 1'b1;
  logic        write_bar = 1'b1;
  wire  [7:0]  data;
  logic        ready;
  logic        bus_error;

  logic [7:0]  tb_data = 8'h00;
  logic        tb_drive = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ref_mem [8192];
  bit         ref_known [8192];

  assign data = tb_drive ? tb_data : 8'hzz;
  pulldown pd (data);

  always #5 clk = ~clk;

  ram_responder #(.WAIT_STATES(WS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .ram_enable(ram_enable),
    .write_bar (write_bar),
    .data      (data),
    .ready     (ready),
    .bus_error (bus_error)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_oob(input logic [15:0] a);
`ifdef RAM_BOUNDS_CHECK_EN
    return a[15:13] != 3'b001;
`else
    return 1'b0;
`endif
  endfunction

  task automatic start(input logic [15:0] a, input bit wr, input logic [7:0] wv);
    @(negedge clk);
    address    = a;
    write_bar  = !wr;
    ram_enable = 1'b0;
    tb_data    = wv;
    tb_drive   = wr;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    for (int i = 1; i <= WS + 10; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        n = i;
        break;
      end
    end
    chk_eq({tag, " latency"}, n, WS + 2);
  endtask

  task automatic release_bus(input string tag);
    @(negedge clk);
    ram_enable = 1'b1;
    write_bar  = 1'b1;
    tb_drive   = 1'b0;
    #1;
    chk_eq({tag, " released"}, data, 0);
    @(posedge clk);
  endtask

  task automatic xact(input logic [15:0] a, input bit wr, input logic [7:0] wv, input string tag);
    bit         oob = model_oob(a);
    logic [12:0] ix = a[12:0];
    start(a, wr, wv);
    wait_ready(tag);
    chk_eq({tag, " bus_error"}, bus_error, oob);
    if (!wr && (oob || ref_known[ix]))
      chk_eq({tag, " rdata"}, data, oob ? 8'hFF : ref_mem[ix]);
    if (wr && !oob) begin
      ref_mem[ix]   = wv;
      ref_known[ix] = 1'b1;
    end
    @(posedge clk);
    #1;
    chk_eq({tag, " ready pulse"}, ready, 0);
    $display("xact %s addr=%04h %s val=%02h oob=%0d", tag, a, wr ? "WR" : "RD", wr ? wv : data, oob);
    release_bus(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset ready", ready, 0);
    chk_eq("reset bus_error", bus_error, 0);
    chk_eq("reset data", data, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Write then read
    xact(16'h2010, 1'b1, 8'hA5, "wr_a5");
    xact(16'h2010, 1'b0, 8'h00, "rd_a5");

    // Wrap and aliasing at the window edges
    xact(16'h3FFF, 1'b1, 8'h3C, "wr_top");
    xact(16'h2000, 1'b1, 8'hC3, "wr_base");
    xact(16'h3FFF, 1'b0, 8'h00, "rd_top");
    xact(16'h2000, 1'b0, 8'h00, "rd_base");

    // Abort during WAIT
    xact(16'h2020, 1'b1, 8'h5A, "wr_pre_abort");
    start(16'h2020, 1'b1, 8'h77);
    @(posedge clk);
    @(negedge clk);
    ram_enable = 1'b1;
    tb_drive   = 1'b0;
    write_bar  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      seen |= ready;
    end
    chk_eq("abort no ready", seen, 0);
    $display("xact abort addr=2020 WR val=77");
    xact(16'h2020, 1'b0, 8'h00, "rd_after_abort");

    // Reset during read HOLD
    xact(16'h2030, 1'b1, 8'h96, "wr_pre_reset");
    start(16'h2030, 1'b0, 8'h00);
    wait_ready("rd_reset");
    chk_eq("rd_reset rdata", data, 8'h96);
    reset_n = 1'b0;
    #1;
    chk_eq("reset_mid ready", ready, 0);
    chk_eq("reset_mid data", data, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    ram_enable = 1'b1;
    @(posedge clk);
    $display("xact reset_mid addr=2030 RD");
    xact(16'h2030, 1'b0, 8'h00, "rd_after_reset");

    // Contention: initiator starts a write strobe during read HOLD
    start(16'h2010, 1'b0, 8'h00);
    wait_ready("rd_cont");
    chk_eq("rd_cont rdata", data, 8'hA5);
    @(negedge clk);
    write_bar = 1'b0;
    #1;
    chk_eq("cont release", data, 0);
    @(negedge clk);
    write_bar = 1'b1;
    #1;
    chk_eq("cont redrive", data, 8'hA5);
    $display("xact contention addr=2010 RD");
    release_bus("rd_cont");

    // Out-of-window access (aliases into the window when the check is disabled)
    xact(16'h4000, 1'b1, 8'h11, "wr_oob");
    xact(16'h2000, 1'b0, 8'h00, "rd_base2");
    xact(16'h4000, 1'b0, 8'h00, "rd_oob");

    // Randomized traffic over a small address pool
    for (int n = 0; n < 80; n++) begin
      logic [12:0] ix;
      logic [2:0]  up;
      ix = 13'($urandom_range(0, 15) * 509);
      up = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b001;
      xact({up, ix}, 1'($urandom_range(0, 1)), 8'($urandom), $sformatf("rand%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
